// File: rtl/noc_arb_pkg.sv
// rtl/noc_arb_pkg.sv - shared arbiter state encoding and flit-type codes
// Contents: arb_state_e (IDLE=1'b0, LOCKED=1'b1) and flit_type_e (HEAD, BODY, TAIL).
// The flit-type codes are shared with the input channel route logic.
package noc_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        FLIT_HEAD = 2'd0,
        FLIT_BODY = 2'd1,
        FLIT_TAIL = 2'd2
    } flit_type_e;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational rotate-and-pick request search
// Ports: req (NUM_IN request vector), ptr (search start index),
//        found (any request set), idx (first set request at or after ptr, wrapping).
module rr_priority_picker #(
    parameter int NUM_IN = 5,
    parameter int PTR_W  = 3
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic              found,
    output logic [PTR_W-1:0]  idx
);

    // Walk offsets from farthest to nearest so the closest request to ptr wins.
    always_comb begin
        int k;
        k     = 0;
        found = 1'b0;
        idx   = '0;
        for (int o = NUM_IN - 1; o >= 0; o--) begin
            k = int'(ptr) + o;
            if (k >= NUM_IN) begin
                k = k - NUM_IN;
            end
            if (req[k]) begin
                found = 1'b1;
                idx   = PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/rr_switch_arbiter.sv
// rtl/rr_switch_arbiter.sv - round-robin wormhole arbiter for one output port
// Ports: clk, rst_n (async active-low); req, in_data, in_tail from input FIFOs;
//        out_full from downstream; read (FIFO pops), out_data, out_write to output;
//        grant (registered lock owner), busy (locked), timeout_err (RR_ARB_TIMEOUT_EN only).
// Optional feature macro: RR_ARB_TIMEOUT_EN (stall timeout with forced lock release).
module rr_switch_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_IN         = 5,
    parameter int DATA_WIDTH     = 8,
    parameter int PTR_W          = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN-1:0]            req,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_tail,
    input  logic                         out_full,
    output logic [NUM_IN-1:0]            read,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_write,
    output logic [NUM_IN-1:0]            grant,
    output logic                         busy
`ifdef RR_ARB_TIMEOUT_EN
    ,
    output logic                         timeout_err
`endif
);

    arb_state_e       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] gidx_inc;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_found;
    logic             xfer;
    logic             tail_xfer;

    rr_priority_picker #(
        .NUM_IN (NUM_IN),
        .PTR_W  (PTR_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Transfer path is gated by registered state, so reset kills it at once.
    assign xfer      = (state == LOCKED) && req[gidx] && !out_full;
    assign tail_xfer = xfer && in_tail[gidx];
    assign gidx_inc  = (gidx == PTR_W'(NUM_IN - 1)) ? '0 : gidx + 1'b1;
    assign out_write = xfer;

    always_comb begin
        read     = '0;
        out_data = '0;
        if (xfer) begin
            read     = NUM_IN'(1) << gidx;
            out_data = in_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] stall_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            gidx  <= '0;
            grant <= '0;
            busy  <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state <= LOCKED;
                        gidx  <= pick_idx;
                        grant <= NUM_IN'(1) << pick_idx;
                        busy  <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                        stall_cnt <= '0;
`endif
                    end
                end
                LOCKED: begin
                    if (tail_xfer) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= gidx_inc;
                    end
`ifdef RR_ARB_TIMEOUT_EN
                    else if (xfer) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // This stall cycle is the TIMEOUT_CYCLES-th: drop the lock.
                        state       <= IDLE;
                        grant       <= '0;
                        busy        <= 1'b0;
                        ptr         <= gidx_inc;
                        timeout_err <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_switch_arbiter.sv
// tb/tb_rr_switch_arbiter.sv - self-checking bench for rr_switch_arbiter
module tb_rr_switch_arbiter;

    localparam int NI = 5;
    localparam int DW = 8;

    logic            clk;
    logic            rst_n;
    logic [NI-1:0]   req;
    logic [NI*DW-1:0] in_data;
    logic [NI-1:0]   in_tail;
    logic            out_full;
    logic [NI-1:0]   read;
    logic [DW-1:0]   out_data;
    logic            out_write;
    logic [NI-1:0]   grant;
    logic            busy;
`ifdef RR_ARB_TIMEOUT_EN
    logic            timeout_err;
`endif

    int total;
    int bad;

    rr_switch_arbiter #(
        .NUM_IN         (NI),
        .DATA_WIDTH     (DW),
        .PTR_W          (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .in_data     (in_data),
        .in_tail     (in_tail),
        .out_full    (out_full),
        .read        (read),
        .out_data    (out_data),
        .out_write   (out_write),
        .grant       (grant),
        .busy        (busy)
`ifdef RR_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rq;
        logic [4:0] tl;
        logic       full;
        logic [4:0] e_read;
        logic       e_write;
        int         src;
        logic [4:0] e_grant;
        logic       e_busy;
    } vec_t;

    vec_t vecs[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slice i carries {tag, i} so the flit source and cycle are both visible.
    task automatic set_data(input logic [3:0] tag);
        for (int i = 0; i < NI; i++) begin
            in_data[i*DW +: DW] = {tag, 4'(i)};
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        in_tail  = '0;
        out_full = 1'b0;
        set_data(4'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] tag;
        logic [4:0] oh;
        total = 0;
        bad   = 0;

        //           req       tail      full rd        wr   src grant     busy
        vecs[0]  = '{5'b00100, 5'b00000, 0, 5'b00000, 0, 0, 5'b00000, 0};
        vecs[1]  = '{5'b00100, 5'b00000, 0, 5'b00100, 1, 2, 5'b00100, 1};
        vecs[2]  = '{5'b00100, 5'b00000, 0, 5'b00100, 1, 2, 5'b00100, 1};
        vecs[3]  = '{5'b00100, 5'b00100, 0, 5'b00100, 1, 2, 5'b00100, 1};
        vecs[4]  = '{5'b11111, 5'b00000, 0, 5'b00000, 0, 0, 5'b00000, 0};
        vecs[5]  = '{5'b11111, 5'b00000, 0, 5'b01000, 1, 3, 5'b01000, 1};
        vecs[6]  = '{5'b11111, 5'b11111, 0, 5'b01000, 1, 3, 5'b01000, 1};
        vecs[7]  = '{5'b11111, 5'b00000, 0, 5'b00000, 0, 0, 5'b00000, 0};
        vecs[8]  = '{5'b11111, 5'b00000, 0, 5'b10000, 1, 4, 5'b10000, 1};
        vecs[9]  = '{5'b11111, 5'b11111, 0, 5'b10000, 1, 4, 5'b10000, 1};
        vecs[10] = '{5'b11111, 5'b00000, 0, 5'b00000, 0, 0, 5'b00000, 0};
        vecs[11] = '{5'b11111, 5'b00000, 0, 5'b00001, 1, 0, 5'b00001, 1};
        vecs[12] = '{5'b11111, 5'b11111, 0, 5'b00001, 1, 0, 5'b00001, 1};
        vecs[13] = '{5'b11111, 5'b00000, 0, 5'b00000, 0, 0, 5'b00000, 0};
        vecs[14] = '{5'b11111, 5'b00000, 0, 5'b00010, 1, 1, 5'b00010, 1};
        vecs[15] = '{5'b11111, 5'b00000, 1, 5'b00000, 0, 0, 5'b00010, 1};
        vecs[16] = '{5'b11111, 5'b00000, 1, 5'b00000, 0, 0, 5'b00010, 1};
        vecs[17] = '{5'b11111, 5'b00000, 1, 5'b00000, 0, 0, 5'b00010, 1};
        vecs[18] = '{5'b11111, 5'b00000, 1, 5'b00000, 0, 0, 5'b00010, 1};
        vecs[19] = '{5'b11111, 5'b00000, 0, 5'b00010, 1, 1, 5'b00010, 1};
        vecs[20] = '{5'b01000, 5'b00000, 0, 5'b00000, 0, 0, 5'b00010, 1};
        vecs[21] = '{5'b01000, 5'b00000, 0, 5'b00000, 0, 0, 5'b00010, 1};
        vecs[22] = '{5'b01010, 5'b00010, 0, 5'b00010, 1, 1, 5'b00010, 1};
        vecs[23] = '{5'b01000, 5'b00000, 0, 5'b00000, 0, 0, 5'b00000, 0};
        vecs[24] = '{5'b01000, 5'b01000, 0, 5'b01000, 1, 3, 5'b01000, 1};
        vecs[25] = '{5'b00000, 5'b00000, 0, 5'b00000, 0, 0, 5'b00000, 0};
        vecs[26] = '{5'b00000, 5'b00000, 0, 5'b00000, 0, 0, 5'b00000, 0};

        do_reset();
        @(negedge clk);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_read", 32'(read), 32'd0);
        check("reset_write", 32'(out_write), 32'd0);
        next_cycle();

        // Directed table: one row per cycle.
        for (int r = 0; r < 27; r++) begin
            tag      = 4'(r);
            req      = vecs[r].rq;
            in_tail  = vecs[r].tl;
            out_full = vecs[r].full;
            set_data(tag);
            @(negedge clk);
            check($sformatf("row%0d_read", r), 32'(read), 32'(vecs[r].e_read));
            check($sformatf("row%0d_write", r), 32'(out_write), 32'(vecs[r].e_write));
            check($sformatf("row%0d_data", r), 32'(out_data),
                  vecs[r].e_write ? 32'({tag, 4'(vecs[r].src)}) : 32'd0);
            check($sformatf("row%0d_grant", r), 32'(grant), 32'(vecs[r].e_grant));
            check($sformatf("row%0d_busy", r), 32'(busy), 32'(vecs[r].e_busy));
            next_cycle();
        end

        // Rotation: all inputs requesting, 2-flit packets, one bubble between packets.
        do_reset();
        req = 5'b11111;
        set_data(4'h7);
        for (int p = 0; p < 6; p++) begin
            oh      = 5'b00001 << (p % 5);
            in_tail = '0;
            @(negedge clk);
            check($sformatf("rot%0d_bubble_grant", p), 32'(grant), 32'd0);
            check($sformatf("rot%0d_bubble_write", p), 32'(out_write), 32'd0);
            next_cycle();
            @(negedge clk);
            check($sformatf("rot%0d_grant", p), 32'(grant), 32'(oh));
            check($sformatf("rot%0d_read1", p), 32'(read), 32'(oh));
            check($sformatf("rot%0d_data1", p), 32'(out_data), 32'({4'h7, 4'(p % 5)}));
            next_cycle();
            in_tail = 5'b11111;
            @(negedge clk);
            check($sformatf("rot%0d_read2", p), 32'(read), 32'(oh));
            next_cycle();
        end
        in_tail = '0;
        req     = '0;
        next_cycle();

        // Reset mid-packet: ptr is 1 here; lock input 4, reset on flit 2 of 4.
        req = 5'b10000;
        next_cycle();
        @(negedge clk);
        check("rst_pkt_grant", 32'(grant), 32'(5'b10000));
        next_cycle();
        @(negedge clk);
        check("rst_pkt_flit2_read", 32'(read), 32'(5'b10000));
        rst_n = 1'b0;
        #1;
        check("rst_mid_read", 32'(read), 32'd0);
        check("rst_mid_write", 32'(out_write), 32'd0);
        check("rst_mid_grant", 32'(grant), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 5'b11111;
        next_cycle();
        @(negedge clk);
        check("rst_restart_grant", 32'(grant), 32'(5'b00001));
        next_cycle();

`ifdef RR_ARB_TIMEOUT_EN
        do_reset();
        req      = 5'b00001;
        out_full = 1'b1;
        next_cycle();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check($sformatf("to_stall%0d_busy", c), 32'(busy), 32'd1);
            check($sformatf("to_stall%0d_err", c), 32'(timeout_err), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check("to_released_busy", 32'(busy), 32'd0);
        check("to_released_grant", 32'(grant), 32'd0);
        check("to_err_set", 32'(timeout_err), 32'd1);
        repeat (5) next_cycle();
        @(negedge clk);
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        do_reset();
        @(negedge clk);
        check("to_err_cleared", 32'(timeout_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
